mem_port_arbiter: RTL and testbench

Shares the core's single memory port between the IFU instruction-fetch requester and the LSU load/store requester. Requests are accepted with a valid/ready handshake, run one at a time on the memory port, and answered with a one-cycle response pulse. The arbiter sits between the pipeline front/back ends and the memory model, so fetch and data accesses never drive the bus at the same time.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter that lets the IFU and the LSU share one memory port. Only one transaction
// is in flight at a time, and each one ends with a single response pulse to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ready,
    input  logic                  if_cancel,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_wen,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wstrb,
    output logic                  ls_ready,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_req,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [1:0] state;
    logic       owner;
    logic       last_grant;
    logic       drop;
    logic       grant_if;
    logic       grant_ls;
    logic       drop_now;
    logic       resp_done;

    // On a tie, the requester that did not win the previous grant gets this one.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE) begin
            if (if_req && ls_req) begin
                grant_ls = (last_grant == OWN_IF);
                grant_if = (last_grant == OWN_LS);
            end else begin
                grant_if = if_req;
                grant_ls = ls_req;
            end
        end
    end

    assign if_ready  = grant_if;
    assign ls_ready  = grant_ls;
    assign mem_req   = (state == REQ);
    assign resp_done = (state == RESP) && mem_rvalid;
    // A cancel that arrives in the same cycle as mem_rvalid still suppresses the response.
    assign drop_now  = drop || (if_cancel && owner == OWN_IF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            drop       <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state      <= REQ;
                        owner      <= OWN_IF;
                        last_grant <= OWN_IF;
                        drop       <= 1'b0;
                        mem_wen    <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                    end else if (grant_ls) begin
                        state      <= REQ;
                        owner      <= OWN_LS;
                        last_grant <= OWN_LS;
                        drop       <= 1'b0;
                        mem_wen    <= ls_wen;
                        mem_addr   <= ls_addr;
                        mem_wdata  <= ls_wdata;
                        mem_wstrb  <= ls_wstrb;
                    end
                end
                REQ: begin
                    if (if_cancel && owner == OWN_IF) drop <= 1'b1;
                    if (mem_ready) state <= RESP;
                end
                RESP: begin
                    if (if_cancel && owner == OWN_IF) drop <= 1'b1;
                    if (mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_rvalid <= resp_done && owner == OWN_IF && !drop_now;
            ls_rvalid <= resp_done && owner == OWN_LS;
            if (resp_done && owner == OWN_IF && !drop_now) if_rdata <= mem_rdata;
            if (resp_done && owner == OWN_LS) ls_rdata <= mem_wen ? '0 : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-timeline model predicts grant,
// memory-phase and response cycles from the delays the bench chooses for each transaction.
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam bit REQ_IF = 1'b0;
    localparam bit REQ_LS = 1'b1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic          if_cancel = 1'b0;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_wen = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic [SW-1:0] ls_wstrb = '0;
    logic          ls_ready;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_cancel(if_cancel),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: the current transaction is described by its grant cycle and the cycles at
    // which the memory accepts it and returns data; everything else follows from those.
    int            cyc = 0;
    int            free_at = 0;
    int            t_g = -100;
    int            t_req_end = -100;
    int            t_rv = -100;
    int            resp_cyc = -100;
    bit            t_own = REQ_IF;
    bit            t_wen = 1'b0;
    bit            t_drop = 1'b0;
    bit            last_g = REQ_IF;
    logic [AW-1:0] t_addr = '0;
    logic [DW-1:0] t_wdata = '0;
    logic [SW-1:0] t_wstrb = '0;
    bit            resp_own = REQ_IF;
    bit            resp_drop = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic [DW-1:0] exp_if_rdata = '0;
    logic [DW-1:0] exp_ls_rdata = '0;

    bit            if_want = 1'b0;
    bit            ls_want = 1'b0;
    bit            ls_w_wen = 1'b0;
    bit            keep_want = 1'b0;
    bit            cancel_now = 1'b0;
    bit            spur = 1'b0;
    bit            fix_en = 1'b0;
    logic [AW-1:0] if_w_addr = '0;
    logic [AW-1:0] ls_w_addr = '0;
    logic [DW-1:0] ls_w_wdata = '0;
    logic [SW-1:0] ls_w_wstrb = '0;
    logic [DW-1:0] fixed_rdata = '0;
    int            next_d1 = 0;
    int            next_d2 = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply_reset();
        if_want = 1'b0;
        ls_want = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        if_cancel = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        reset = 1'b0;
        #1;
        check_output("rst_if_ready", if_ready, 0);
        check_output("rst_ls_ready", ls_ready, 0);
        check_output("rst_mem_req", mem_req, 0);
        check_output("rst_mem_wen", mem_wen, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_wdata", mem_wdata, 0);
        check_output("rst_mem_wstrb", mem_wstrb, 0);
        check_output("rst_if_rvalid", if_rvalid, 0);
        check_output("rst_ls_rvalid", ls_rvalid, 0);
        check_output("rst_if_rdata", if_rdata, 0);
        check_output("rst_ls_rdata", ls_rdata, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
        free_at = cyc;
        t_g = -100;
        t_req_end = -100;
        t_rv = -100;
        resp_cyc = -100;
        t_own = REQ_IF;
        t_drop = 1'b0;
        last_g = REQ_IF;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    // One clock cycle: drive inputs, predict outputs, compare, advance past the edge.
    task automatic apply_stimulus();
        bit            idle;
        bit            in_req;
        bit            in_resp;
        bit            gi;
        bit            gl;
        bit            exp_ifv;
        bit            exp_lsv;
        bit            exp_mreq;
        logic [DW-1:0] rd;

        idle    = (cyc >= free_at);
        in_req  = (cyc >= t_g + 1) && (cyc <= t_req_end);
        in_resp = (cyc > t_req_end) && (cyc <= t_rv);
        rd = fix_en ? fixed_rdata : {$urandom, $urandom};
        mem_rdata  = rd;
        mem_ready  = in_req ? (cyc == t_req_end) : (spur && $urandom_range(0, 1) == 1);
        mem_rvalid = in_resp ? (cyc == t_rv) : (spur && $urandom_range(0, 1) == 1);
        if_cancel  = cancel_now;
        if (cancel_now && t_own == REQ_IF && cyc >= t_g + 1 && cyc <= t_rv) t_drop = 1'b1;

        exp_ifv = (cyc == resp_cyc) && resp_own == REQ_IF && !resp_drop;
        exp_lsv = (cyc == resp_cyc) && resp_own == REQ_LS;
        if (exp_ifv) exp_if_rdata = resp_data;
        if (exp_lsv) exp_ls_rdata = resp_data;
        if (cyc == t_rv) begin
            resp_cyc  = cyc + 1;
            resp_own  = t_own;
            resp_drop = t_drop;
            resp_data = t_wen ? '0 : rd;
        end

        gi = 1'b0;
        gl = 1'b0;
        if (idle) begin
            if (if_want && ls_want) begin
                gl = (last_g == REQ_IF);
                gi = !gl;
            end else begin
                gi = if_want;
                gl = ls_want;
            end
        end
        if (gi || gl) begin
            t_g       = cyc;
            t_own     = gl;
            last_g    = gl;
            t_drop    = 1'b0;
            t_req_end = cyc + 1 + next_d1;
            t_rv      = t_req_end + 1 + next_d2;
            free_at   = t_rv + 1;
            t_addr    = gl ? ls_w_addr : if_w_addr;
            t_wen     = gl && ls_w_wen;
            t_wdata   = gl ? ls_w_wdata : '0;
            t_wstrb   = gl ? ls_w_wstrb : '0;
        end
        exp_mreq = (cyc >= t_g + 1) && (cyc <= t_req_end);

        if_req   = if_want;
        if_addr  = if_w_addr;
        ls_req   = ls_want;
        ls_wen   = ls_w_wen;
        ls_addr  = ls_w_addr;
        ls_wdata = ls_w_wdata;
        ls_wstrb = ls_w_wstrb;
        #1;
        check_output("if_ready", if_ready, gi);
        check_output("ls_ready", ls_ready, gl);
        check_output("mem_req", mem_req, exp_mreq);
        if (exp_mreq) begin
            check_output("mem_addr", mem_addr, t_addr);
            check_output("mem_wen", mem_wen, t_wen);
            check_output("mem_wstrb", mem_wstrb, t_wstrb);
            if (t_own == REQ_LS) check_output("mem_wdata", mem_wdata, t_wdata);
        end
        check_output("if_rvalid", if_rvalid, exp_ifv);
        check_output("ls_rvalid", ls_rvalid, exp_lsv);
        check_output("if_rdata", if_rdata, exp_if_rdata);
        check_output("ls_rdata", ls_rdata, exp_ls_rdata);

        if (gi && !keep_want) if_want = 1'b0;
        if (gl && !keep_want) ls_want = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        #2;
        apply_reset();

        $display("[TB] single IFU fetch");
        fix_en = 1'b1;
        fixed_rdata = 64'h0000_0013_0010_0093;
        next_d1 = 0;
        next_d2 = 0;
        if_w_addr = 64'h8000_0000;
        if_want = 1'b1;
        repeat (5) apply_stimulus();
        fix_en = 1'b0;

        $display("[TB] LSU write with delayed mem_ready");
        next_d1 = 2;
        ls_w_wen = 1'b1;
        ls_w_addr = 64'h8000_1000;
        ls_w_wdata = 64'hDEAD_BEEF;
        ls_w_wstrb = 8'h0F;
        ls_want = 1'b1;
        repeat (7) apply_stimulus();

        $display("[TB] both requesters continuously from reset");
        apply_reset();
        next_d1 = 0;
        next_d2 = 0;
        ls_w_wen = 1'b0;
        ls_w_addr = 64'h8000_2000;
        if_w_addr = 64'h8000_0040;
        keep_want = 1'b1;
        if_want = 1'b1;
        ls_want = 1'b1;
        repeat (13) apply_stimulus();
        keep_want = 1'b0;
        if_want = 1'b0;
        ls_want = 1'b0;
        repeat (4) apply_stimulus();

        $display("[TB] IFU cancel in RESP with LSU waiting");
        next_d1 = 0;
        next_d2 = 1;
        if_w_addr = 64'h8000_0100;
        if_want = 1'b1;
        apply_stimulus();
        ls_w_addr = 64'h8000_3000;
        ls_want = 1'b1;
        apply_stimulus();
        cancel_now = 1'b1;
        apply_stimulus();
        cancel_now = 1'b0;
        repeat (7) apply_stimulus();

        $display("[TB] reset during an LSU read");
        next_d1 = 3;
        next_d2 = 0;
        ls_w_wen = 1'b0;
        ls_want = 1'b1;
        repeat (2) apply_stimulus();
        apply_reset();
        next_d1 = 0;
        if_w_addr = 64'h8000_0200;
        if_want = 1'b1;
        repeat (6) apply_stimulus();

        $display("[TB] spurious mem_ready and mem_rvalid");
        spur = 1'b1;
        next_d1 = 2;
        next_d2 = 1;
        repeat (3) apply_stimulus();
        ls_w_addr = 64'h8000_4000;
        ls_want = 1'b1;
        repeat (8) apply_stimulus();

        $display("[TB] randomized traffic");
        repeat (400) begin
            if (!if_want && $urandom_range(0, 2) == 0) begin
                if_want = 1'b1;
                if_w_addr = {$urandom, $urandom};
            end
            if (!ls_want && $urandom_range(0, 2) == 0) begin
                ls_want = 1'b1;
                ls_w_wen = ($urandom_range(0, 1) == 1);
                ls_w_addr = {$urandom, $urandom};
                ls_w_wdata = {$urandom, $urandom};
                ls_w_wstrb = SW'($urandom_range(0, 255));
            end
            next_d1 = $urandom_range(0, 3);
            next_d2 = $urandom_range(0, 3);
            cancel_now = ($urandom_range(0, 7) == 0);
            apply_stimulus();
        end
        cancel_now = 1'b0;
        if_want = 1'b0;
        ls_want = 1'b0;
        repeat (10) apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
